multiply_divide_unit: RTL and testbench
=======================================

Name: multiply_divide_unit

Overview:
- Execution-stage HI/LO unit; consumes the 5-bit multiply control word produced by the EX controller plus the two register operands.
- Performs multi-cycle mult/multu/div/divu and single-cycle mthi/mtlo.
- Exposes HI or LO to the EX result mux for mfhi/mflo.
- Drives `busy`, which the hazard unit uses to stall any later HI/LO instruction.

Parameters:
- MULT_CYCLES, 5, cycles `busy` stays high for mult/multu (must be >= 1)
- DIV_CYCLES, 10, cycles `busy` stays high for div/divu (must be >= 1)

Ports:
- clk  input  1  rising-edge clock
- reset_n  input  1  asynchronous, active-low reset
- ctrl  input  5  {launch, divide, unsigned, move, target_lo}; all zero = no-op or mfhi
- A  input  32  rs operand (dividend, multiplicand, or mthi/mtlo source)
- B  input  32  rt operand (divisor or multiplier)
- busy  output  1  registered; high while an operation is in flight
- out  output  32  combinational; target_lo ? LO : HI
- HI  output  32  architectural HI register, for debug
- LO  output  32  architectural LO register, for debug

Behaviour:
- Decoding of ctrl:
  - launch = ctrl[4], divide = ctrl[3], unsigned = ctrl[2], move = ctrl[1], target_lo = ctrl[0].
  - Resulting encodings: mult 10000, multu 10100, div 11001, divu 11101, mthi 00110, mtlo 01111, mflo 01001, mfhi/no-op 00000.
- Reset (async, reset_n low):
  - HI = 0, LO = 0, busy = 0, counter = 0, operand latches = 0, state = IDLE.
  - Reset asserted mid-operation aborts it; HI/LO are not updated.
- States: IDLE and RUN.
  - A 32-bit count register tracks remaining cycles.
- Launch accepted at rising edge k only when state = IDLE and launch = 1:
  - Latch A, B, divide, unsigned.
  - count = (divide ? DIV_CYCLES : MULT_CYCLES).
  - busy = 1 and state = RUN after edge k.
- In RUN, each edge decrements count.
  - On the edge where count goes 1 -> 0: write HI/LO, busy = 0, state = IDLE. This happens in one and the same edge.
  - Result is visible on `out` the cycle after that edge.
- Total latency: the launch instruction's result is readable exactly N cycles after edge k (N = MULT_CYCLES or DIV_CYCLES).
- Multiply results:
  - Signed: {HI, LO} = $signed(A) * $signed(B), full 64 bits.
  - Unsigned: {HI, LO} = A * B, full 64 bits.
- Divide results:
  - LO = quotient truncated toward zero; HI = remainder, which takes the sign of the dividend.
  - Unsigned divide treats both operands as unsigned.
  - Divide by zero (latched B == 0): operation runs its full DIV_CYCLES with busy high, but HI/LO are left unchanged.
- Move (mthi/mtlo), only when state = IDLE and launch = 0 and move = 1:
  - At the edge, HI = A (target_lo = 0) or LO = A (target_lo = 1).
  - busy is unaffected.
- Any ctrl arriving while state = RUN is ignored; the hazard unit guarantees it never occurs.
  - It must not corrupt the latched operands, the counter, or HI/LO.
- out is purely combinational from current HI/LO and ctrl[0]; it has no cycle of delay.
- Arithmetic may be computed combinationally on the latched operands; the counter only models latency. A serial implementation is also acceptable if the results and timing match.

Test Plan:
- Reset: pulse reset_n low asynchronously between edges -> HI = LO = 0 and busy = 0 immediately, with no clock edge needed.
- Multiply:
  - mult A=0xFFFFFFFF, B=0xFFFFFFFF -> busy high exactly 5 cycles, then HI = 0x00000000, LO = 0x00000001.
  - multu with the same operands -> HI = 0xFFFFFFFE, LO = 0x00000001.
- Signed divide: div A=0xFFFFFFF9 (-7), B=2 -> busy high exactly 10 cycles, then LO = 0xFFFFFFFD, HI = 0xFFFFFFFF.
- Unsigned divide: divu with the same operands -> LO = 0x7FFFFFFC, HI = 0x00000001.
- Divide by zero: preload HI = 0x11111111, LO = 0x22222222 via mthi/mtlo, then div A=5, B=0 -> busy high 10 cycles; HI/LO unchanged.
- Ignored ctrl while busy: launch mult 3*4, then on the next cycle drive mtlo A=0xDEAD and div -> both ignored; after 5 cycles LO = 12, HI = 0, busy = 0.
- Reset mid-operation: launch div 100/7 and assert reset_n low on cycle 4 -> busy = 0, HI = LO = 0.
- Post-reset sanity: after the mid-operation reset, launch mult 2*3 -> LO = 6 after 5 cycles.
- out mux: with HI = 0xA, LO = 0xB, ctrl = 01001 -> out = 0xB; ctrl = 00000 -> out = 0xA, in the same cycle.

Source files
------------

// File: rtl/multiply_divide_unit.sv
// HI/LO execution unit: multi-cycle mult/multu/div/divu with single-cycle mthi/mtlo.
// Arithmetic is combinational on latched operands; the counter models the pipeline latency.
module multiply_divide_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [4:0]  ctrl,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        busy,
  output logic [31:0] out,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t      state_reg, state_next;
  logic [31:0] count_reg, count_next;
  logic [31:0] a_reg, a_next;
  logic [31:0] b_reg, b_next;
  logic        div_reg, div_next;
  logic        uns_reg, uns_next;
  logic [31:0] hi_reg, hi_next;
  logic [31:0] lo_reg, lo_next;
  logic        busy_reg, busy_next;

  logic launch, divide, is_unsigned, move, target_lo;
  assign {launch, divide, is_unsigned, move, target_lo} = ctrl;

  logic signed [63:0] prod_s;
  logic        [63:0] prod_u;
  logic        [31:0] b_safe;
  logic signed [31:0] quo_s, rem_s;
  logic        [31:0] quo_u, rem_u;

  assign prod_s = $signed({{32{a_reg[31]}}, a_reg}) * $signed({{32{b_reg[31]}}, b_reg});
  assign prod_u = {32'd0, a_reg} * {32'd0, b_reg};
  // Divisor of zero is replaced so the dividers never see it; the result is discarded anyway.
  assign b_safe = (b_reg == 32'd0) ? 32'd1 : b_reg;
  assign quo_s  = $signed(a_reg) / $signed(b_safe);
  assign rem_s  = $signed(a_reg) % $signed(b_safe);
  assign quo_u  = a_reg / b_safe;
  assign rem_u  = a_reg % b_safe;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= IDLE;
      count_reg <= '0;
      a_reg     <= '0;
      b_reg     <= '0;
      div_reg   <= 1'b0;
      uns_reg   <= 1'b0;
      hi_reg    <= '0;
      lo_reg    <= '0;
      busy_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      count_reg <= count_next;
      a_reg     <= a_next;
      b_reg     <= b_next;
      div_reg   <= div_next;
      uns_reg   <= uns_next;
      hi_reg    <= hi_next;
      lo_reg    <= lo_next;
      busy_reg  <= busy_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    count_next = count_reg;
    a_next     = a_reg;
    b_next     = b_reg;
    div_next   = div_reg;
    uns_next   = uns_reg;
    hi_next    = hi_reg;
    lo_next    = lo_reg;
    busy_next  = busy_reg;
    case (state_reg)
      IDLE: begin
        if (launch) begin
          a_next     = A;
          b_next     = B;
          div_next   = divide;
          uns_next   = is_unsigned;
          count_next = divide ? 32'(DIV_CYCLES) : 32'(MULT_CYCLES);
          busy_next  = 1'b1;
          state_next = RUN;
        end else if (move) begin
          if (target_lo) lo_next = A;
          else           hi_next = A;
        end
      end
      RUN: begin
        // ctrl is deliberately ignored here; only the countdown advances.
        count_next = count_reg - 32'd1;
        if (count_reg == 32'd1) begin
          busy_next  = 1'b0;
          state_next = IDLE;
          if (!div_reg) begin
            {hi_next, lo_next} = uns_reg ? prod_u : prod_s;
          end else if (b_reg != 32'd0) begin
            lo_next = uns_reg ? quo_u : quo_s;
            hi_next = uns_reg ? rem_u : rem_s;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign busy = busy_reg;
  assign HI   = hi_reg;
  assign LO   = lo_reg;
  assign out  = ctrl[0] ? lo_reg : hi_reg;

endmodule

// File: tb/tb_multiply_divide_unit.sv
// Directed bench for multiply_divide_unit: expected HI/LO pairs are queued at launch
// and compared when busy falls.
module tb_multiply_divide_unit;

  localparam int MC = 5;
  localparam int DC = 10;
  localparam logic [4:0] OP_MULT  = 5'b10000;
  localparam logic [4:0] OP_MULTU = 5'b10100;
  localparam logic [4:0] OP_DIV   = 5'b11001;
  localparam logic [4:0] OP_DIVU  = 5'b11101;
  localparam logic [4:0] OP_MTHI  = 5'b00110;
  localparam logic [4:0] OP_MTLO  = 5'b01111;
  localparam logic [4:0] OP_MFLO  = 5'b01001;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [4:0]  ctrl;
  logic [31:0] A, B;
  logic        busy;
  logic [31:0] out, HI, LO;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] exp_hi_q[$];
  logic [31:0] exp_lo_q[$];

  multiply_divide_unit #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk(clk), .reset_n(reset_n), .ctrl(ctrl), .A(A), .B(B),
    .busy(busy), .out(out), .HI(HI), .LO(LO)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input logic [31:0] hi, input logic [31:0] lo);
    exp_hi_q.push_back(hi);
    exp_lo_q.push_back(lo);
  endtask

  // Drive an op for one edge; returns #1 after that edge with ctrl back to no-op.
  task automatic issue(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    ctrl = op; A = a; B = b;
    @(posedge clk);
    #1 ctrl = 5'b00000;
  endtask

  // Called #1 after the launch edge; busy must stay high n cycles then drop with the result.
  task automatic wait_done(input string tag, input int n, input bit interfere);
    logic [31:0] eh, el;
    check({tag, "_busy0"}, {31'd0, busy}, 32'd1);
    if (interfere) begin ctrl = OP_MTLO; A = 32'h0000DEAD; end
    for (int i = 1; i < n; i++) begin
      @(posedge clk); #1;
      check($sformatf("%s_busy%0d", tag, i), {31'd0, busy}, 32'd1);
      if (interfere && i == 1) begin ctrl = OP_DIV; A = 32'd9; B = 32'd3; end
      if (interfere && i == 2) ctrl = 5'b00000;
    end
    @(posedge clk); #1;
    check({tag, "_busy_end"}, {31'd0, busy}, 32'd0);
    if (exp_hi_q.size() == 0) begin
      check({tag, "_queue"}, 32'd0, 32'd1);
    end else begin
      eh = exp_hi_q.pop_front();
      el = exp_lo_q.pop_front();
      check({tag, "_HI"}, HI, eh);
      check({tag, "_LO"}, LO, el);
      $display("%s done HI=%h LO=%h", tag, HI, LO);
    end
  endtask

  initial begin
    ctrl = 5'b00000; A = '0; B = '0;
    reset_n = 1'b1;
    #1 reset_n = 1'b0;
    #1;
    check("rst_HI", HI, 32'd0);
    check("rst_LO", LO, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    @(negedge clk); @(negedge clk);
    reset_n = 1'b1;

    push_exp(32'h00000000, 32'h00000001);
    issue(OP_MULT, 32'hFFFFFFFF, 32'hFFFFFFFF);
    wait_done("mult", MC, 1'b0);

    push_exp(32'hFFFFFFFE, 32'h00000001);
    issue(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF);
    wait_done("multu", MC, 1'b0);

    push_exp(32'hFFFFFFFF, 32'hFFFFFFFD);
    issue(OP_DIV, 32'hFFFFFFF9, 32'd2);
    wait_done("div", DC, 1'b0);

    push_exp(32'h00000001, 32'h7FFFFFFC);
    issue(OP_DIVU, 32'hFFFFFFF9, 32'd2);
    wait_done("divu", DC, 1'b0);

    issue(OP_MTHI, 32'h11111111, 32'd0);
    check("mthi_HI", HI, 32'h11111111);
    check("mthi_busy", {31'd0, busy}, 32'd0);
    issue(OP_MTLO, 32'h22222222, 32'd0);
    check("mtlo_LO", LO, 32'h22222222);
    check("mtlo_HI", HI, 32'h11111111);
    $display("move HI=%h LO=%h", HI, LO);

    push_exp(32'h11111111, 32'h22222222);
    issue(OP_DIV, 32'd5, 32'd0);
    wait_done("div0", DC, 1'b0);

    push_exp(32'h00000000, 32'h0000000C);
    issue(OP_MULT, 32'd3, 32'd4);
    wait_done("ignore", MC, 1'b1);

    issue(OP_DIV, 32'd100, 32'd7);
    repeat (3) @(posedge clk);
    #3 reset_n = 1'b0;
    #1;
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_HI", HI, 32'd0);
    check("midrst_LO", LO, 32'd0);
    $display("midrst busy=%0b HI=%h LO=%h", busy, HI, LO);
    @(negedge clk);
    reset_n = 1'b1;

    push_exp(32'h00000000, 32'h00000006);
    issue(OP_MULT, 32'd2, 32'd3);
    wait_done("post_rst", MC, 1'b0);

    issue(OP_MTHI, 32'h0000000A, 32'd0);
    issue(OP_MTLO, 32'h0000000B, 32'd0);
    @(negedge clk);
    ctrl = OP_MFLO;
    #1 check("mflo_out", out, 32'h0000000B);
    ctrl = 5'b00000;
    #1 check("mfhi_out", out, 32'h0000000A);
    $display("outmux HI=%h LO=%h out=%h", HI, LO, out);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
